// File: rtl/console_pkg.sv
// Shared constants, status-word layout and drain FSM encoding for the console controller.
package console_pkg;

  localparam logic [31:0] CONSOLE_ADDR_DEF = 32'h0000_FFFC;
  localparam logic [31:0] STATUS_ADDR_DEF  = 32'h0000_FFF8;

  localparam int unsigned EMPTY_BIT = 0;
  localparam int unsigned FULL_BIT  = 1;
  localparam int unsigned COUNT_LSB = 8;
  localparam int unsigned COUNT_W   = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESENT = 2'd1,
    GAP     = 2'd2
  } drain_state_t;

endpackage

// File: rtl/console_fifo.sv
// DEPTH-entry synchronous FIFO; caller guarantees no push when full and no pop when empty.
module console_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  assign head  = mem[rd_ptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == CW'(0));

endmodule

// File: rtl/console_mmio_ctrl.sv
// Memory-mapped console: buffers core stores, paces them out to a valid/ready sink.
// Define CONSOLE_DROP_EN to drop (and count) words on overflow instead of stalling the core.
module console_mmio_ctrl
  import console_pkg::*;
#(
  parameter int unsigned DEPTH        = 8,
  parameter logic [31:0] CONSOLE_ADDR = CONSOLE_ADDR_DEF,
  parameter logic [31:0] STATUS_ADDR  = STATUS_ADDR_DEF,
  parameter int unsigned TX_GAP       = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memwrite,
  input  logic        memread,
  input  logic [31:0] dataadr,
  input  logic [31:0] writedata,
  output logic        stall,
  output logic [31:0] rdata,
  output logic        tx_valid,
  output logic [31:0] tx_data,
  input  logic        tx_ready,
  output logic [15:0] drop_cnt
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned GW = (TX_GAP > 0) ? $clog2(TX_GAP + 1) : 1;

  logic          push_req;
  logic          push;
  logic          pop;
  logic          full;
  logic          empty;
  logic [CW-1:0] count;
  logic [31:0]   head;

  drain_state_t  state;
  drain_state_t  state_n;
  logic [GW-1:0] gap_cnt;
  logic [GW-1:0] gap_n;

  // Registered full flag only: a same-cycle pop never unblocks a store.
  assign push_req = memwrite && (dataadr == CONSOLE_ADDR) && !reset;
  assign push     = push_req && !full;

  console_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .wdata (writedata),
    .head  (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  always_comb begin
    rdata = '0;
    if (memread && (dataadr == STATUS_ADDR)) begin
      rdata[COUNT_LSB +: COUNT_W] = COUNT_W'(count);
      rdata[FULL_BIT]             = full;
      rdata[EMPTY_BIT]            = empty;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      gap_cnt <= '0;
    end else begin
      state   <= state_n;
      gap_cnt <= gap_n;
    end
  end

  always_comb begin
    state_n = state;
    gap_n   = gap_cnt;
    pop     = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) state_n = PRESENT;
      end
      PRESENT: begin
        if (tx_ready) begin
          pop   = 1'b1;
          gap_n = GW'(TX_GAP);
          if (TX_GAP > 0)             state_n = GAP;
          else if (count > CW'(1))    state_n = PRESENT;
          else                        state_n = IDLE;
        end
      end
      GAP: begin
        gap_n = gap_cnt - GW'(1);
        if (gap_cnt <= GW'(1)) state_n = empty ? IDLE : PRESENT;
      end
      default: state_n = IDLE;
    endcase
  end

  assign tx_valid = (state == PRESENT);
  assign tx_data  = head;

`ifdef CONSOLE_DROP_EN
  logic [15:0] drop_q;

  // Overflowing stores are discarded; counter saturates rather than wrapping.
  always_ff @(posedge clk) begin
    if (reset) begin
      drop_q <= '0;
    end else if (push_req && full && (drop_q != 16'hFFFF)) begin
      drop_q <= drop_q + 16'd1;
    end
  end

  assign stall    = 1'b0;
  assign drop_cnt = drop_q;
`else
  assign stall    = push_req && full;
  assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_console_mmio_ctrl.sv
// Randomized and directed bench for console_mmio_ctrl against a queue-based transaction model.
module tb_console_mmio_ctrl;

  localparam int unsigned DEPTH  = 8;
  localparam int unsigned TX_GAP = 4;
  localparam logic [31:0] CADR   = 32'h0000_FFFC;
  localparam logic [31:0] SADR   = 32'h0000_FFF8;
`ifdef CONSOLE_DROP_EN
  localparam bit DROP_EN = 1'b1;
`else
  localparam bit DROP_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        memwrite;
  logic        memread;
  logic [31:0] dataadr;
  logic [31:0] writedata;
  logic        stall;
  logic [31:0] rdata;
  logic        tx_valid;
  logic [31:0] tx_data;
  logic        tx_ready;
  logic [15:0] drop_cnt;

  console_mmio_ctrl #(
    .DEPTH        (DEPTH),
    .CONSOLE_ADDR (CADR),
    .STATUS_ADDR  (SADR),
    .TX_GAP       (TX_GAP)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .memwrite  (memwrite),
    .memread   (memread),
    .dataadr   (dataadr),
    .writedata (writedata),
    .stall     (stall),
    .rdata     (rdata),
    .tx_valid  (tx_valid),
    .tx_data   (tx_data),
    .tx_ready  (tx_ready),
    .drop_cnt  (drop_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Model: buffered words, whether a word is on offer, time of last accepted transfer.
  logic [31:0] q[$];
  bit          mvalid;
  int          last_pop;
  int          cyc_n;
  int          mdrop;
  bit          exp_stall;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc_n);
    end
  endtask

  task automatic model_reset();
    q.delete();
    mvalid   = 1'b0;
    last_pop = -1000;
    mdrop    = 0;
  endtask

  // One clock: check outputs mid-cycle, then advance the model across the edge.
  task automatic step();
    int          sz;
    bit          mfull;
    bit          preq;
    bit          acc;
    logic [31:0] er;
    @(negedge clk);
    sz    = q.size();
    mfull = (sz == DEPTH);
    preq  = memwrite && (dataadr == CADR) && !reset;
    er    = 32'h0;
    if (memread && dataadr == SADR)
      er = {16'h0, 8'(sz), 6'h0, mfull, (sz == 0)};
    exp_stall = !DROP_EN && preq && mfull;
    check("stall", 32'(stall), 32'(exp_stall));
    check("rdata", rdata, er);
    check("tx_valid", 32'(tx_valid), 32'(mvalid));
    if (mvalid) check("tx_data", tx_data, q[0]);
    check("drop_cnt", 32'(drop_cnt), 32'(mdrop));
    acc = mvalid && tx_ready;
    if (reset) begin
      model_reset();
    end else begin
      if (acc) last_pop = cyc_n;
      mvalid = (mvalid && !acc) ||
               ((cyc_n + 1 >= last_pop + int'(TX_GAP) + 1) && (sz - int'(acc) > 0));
      if (acc) void'(q.pop_front());
      if (preq && !mfull) q.push_back(writedata);
      if (preq && mfull && DROP_EN && mdrop < 65535) mdrop++;
    end
    cyc_n++;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    memwrite  = 1'b0;
    memread   = 1'b0;
    dataadr   = 32'h0;
    writedata = 32'h0;
  endtask

  task automatic store_word(input logic [31:0] w);
    int n;
    memwrite  = 1'b1;
    memread   = 1'b0;
    dataadr   = CADR;
    writedata = w;
    n = 0;
    do begin
      step();
      n++;
    end while (exp_stall && n < 40);
    if (exp_stall) check("store_timeout", 32'(n), 32'(0));
    idle_inputs();
  endtask

  task automatic status_read();
    memwrite = 1'b0;
    memread  = 1'b1;
    dataadr  = SADR;
    step();
    idle_inputs();
  endtask

  initial begin
    int sel;
    bit hold;
    cyc_n    = 0;
    reset    = 1'b1;
    tx_ready = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    step();
    reset = 1'b0;
    status_read();

    // Single word with a ready sink: two-cycle latency then the pacing gap.
    tx_ready = 1'b1;
    store_word(32'h0000_0041);
    repeat (10) step();

    // Backpressure: fill, stall on the ninth store, read status, then drain.
    tx_ready = 1'b0;
    for (int w = 1; w <= 8; w++) store_word(32'(w));
    memwrite  = 1'b1;
    dataadr   = CADR;
    writedata = 32'd9;
    repeat (2) step();
    idle_inputs();
    status_read();
    tx_ready = 1'b1;
    store_word(32'd9);
    repeat (60) step();

    // Non-console traffic.
    memwrite = 1'b1; dataadr = 32'h0000_0100; writedata = 32'hDEAD_BEEF; step();
    memwrite = 1'b0; memread = 1'b1; dataadr = CADR; step();
    idle_inputs();
    status_read();

    // Reset while the drain engine is pacing with words still buffered.
    tx_ready = 1'b0;
    for (int w = 0; w < 6; w++) store_word(32'h100 + 32'(w));
    repeat (2) step();
    tx_ready = 1'b1;
    step();
    tx_ready = 1'b0;
    repeat (2) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    status_read();
    repeat (3) step();

    // Random traffic: stalled stores are held by the core until accepted.
    hold = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (!hold) begin
        sel = int'($urandom_range(0, 9));
        idle_inputs();
        if (sel <= 4) begin
          memwrite = 1'b1; dataadr = CADR; writedata = $urandom();
        end else if (sel <= 6) begin
          memread = 1'b1; dataadr = SADR;
        end else if (sel == 7) begin
          memwrite = 1'b1; dataadr = 32'h0000_0100; writedata = $urandom();
        end else if (sel == 8) begin
          memread = 1'b1; dataadr = CADR;
        end
      end
      if (((i / 300) % 2) == 1) tx_ready = ($urandom_range(0, 3) == 0);
      else                      tx_ready = ($urandom_range(0, 3) != 0);
      reset = ($urandom_range(0, 299) == 0);
      step();
      hold = exp_stall;
    end
    reset    = 1'b0;
    tx_ready = 1'b1;
    idle_inputs();
    repeat (80) step();
    status_read();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
